// File: rtl/video_mode_ctrl.sv
// Frame-synchronous video lock detector and processing-mode selector for the HDMI path.
// Mode changes are applied only on VS rises while locked; passthrough is forced otherwise.
//
// state   | meaning
// NOSIG   | no frame boundary seen recently, counters idle
// MEASURE | frames are being measured, waiting for LOCK_FRAMES matches
// LOCKED  | stable timing, mode_o follows mode_sw at each frame start
module video_mode_ctrl #(
  parameter int WIDTH_BITS    = 12,
  parameter int HEIGHT_BITS   = 12,
  parameter int LOCK_FRAMES   = 2,
  parameter int FRAME_TIMEOUT = 4_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   de,
  input  logic                   hs,
  input  logic                   vs,
  input  logic [1:0]             mode_sw,
  output logic [1:0]             mode_o,
  output logic                   frame_start,
  output logic                   locked,
  output logic [WIDTH_BITS-1:0]  active_width,
  output logic [HEIGHT_BITS-1:0] active_height,
  output logic [3:0]             status
);

  localparam logic [1:0] NOSIG   = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam int MATCH_BITS = $clog2(LOCK_FRAMES + 1);
  localparam int TO_BITS    = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [MATCH_BITS-1:0]  MATCH_LOCK = MATCH_BITS'(LOCK_FRAMES);
  localparam logic [TO_BITS-1:0]     TO_LAST    = TO_BITS'(FRAME_TIMEOUT - 1);
  localparam logic [TO_BITS-1:0]     TO_MAX     = '1;
  localparam logic [WIDTH_BITS-1:0]  W_MAX      = '1;
  localparam logic [HEIGHT_BITS-1:0] H_MAX      = '1;

  logic                   de_q, de_qq, vs_q, vs_qq;
  logic [1:0]             mode_meta, mode_sync;
  logic [1:0]             state;
  logic [WIDTH_BITS-1:0]  pix_cnt, cur_w, ref_w;
  logic [HEIGHT_BITS-1:0] line_cnt, ref_h;
  logic                   frame_bad, skip_line;
  logic [MATCH_BITS-1:0]  match_cnt;
  logic [TO_BITS-1:0]     to_cnt;
  logic                   last_bad, lock_lost;

  logic                   unused_hs;
  assign unused_hs = hs;

  logic                   de_fall, vs_rise, close_line, first_line;
  logic                   bad_eval, good, same, timeout;
  logic [WIDTH_BITS-1:0]  w_eval;
  logic [HEIGHT_BITS-1:0] h_eval;
  logic [MATCH_BITS-1:0]  match_next;

  assign de_fall = ~de_q & de_qq;
  assign vs_rise = vs_q & ~vs_qq;
  assign status  = {lock_lost, last_bad, state};

  // Frame result as it would look with this cycle's line close folded in,
  // so a DE fall coinciding with the VS rise still belongs to the old frame.
  always_comb begin
    close_line = de_fall & ~skip_line;
    first_line = (line_cnt == '0);
    w_eval     = (close_line && first_line) ? pix_cnt : cur_w;
    h_eval     = (close_line && line_cnt != H_MAX) ? line_cnt + 1'b1 : line_cnt;
    bad_eval   = frame_bad
               | (close_line && !first_line && pix_cnt != cur_w)
               | (close_line && line_cnt == H_MAX)
               | (de_q && pix_cnt == W_MAX);
    good       = ~bad_eval && (h_eval != '0) && (w_eval != '0);
    same       = (w_eval == ref_w) && (h_eval == ref_h);
    match_next = '0;
    if (good) begin
      if (!same)                   match_next = MATCH_BITS'(1);
      else if (match_cnt == MATCH_LOCK) match_next = match_cnt;
      else                         match_next = match_cnt + 1'b1;
    end
    timeout = ~vs_rise && (to_cnt >= TO_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de_q      <= 1'b0;
      de_qq     <= 1'b0;
      vs_q      <= 1'b0;
      vs_qq     <= 1'b0;
      mode_meta <= '0;
      mode_sync <= '0;
    end else begin
      de_q      <= de;
      de_qq     <= de_q;
      vs_q      <= vs;
      vs_qq     <= vs_q;
      mode_meta <= mode_sw;
      mode_sync <= mode_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt   <= '0;
      cur_w     <= '0;
      line_cnt  <= '0;
      frame_bad <= 1'b0;
      skip_line <= 1'b0;
    end else if (vs_rise) begin
      pix_cnt   <= '0;
      cur_w     <= '0;
      line_cnt  <= '0;
      frame_bad <= 1'b0;
      skip_line <= de_q;
    end else if (de_fall) begin
      pix_cnt   <= '0;
      skip_line <= 1'b0;
      if (!skip_line) begin
        if (first_line) cur_w <= pix_cnt;
        else if (pix_cnt != cur_w) frame_bad <= 1'b1;
        if (line_cnt == H_MAX) frame_bad <= 1'b1;
        else line_cnt <= line_cnt + 1'b1;
      end
    end else if (de_q) begin
      if (pix_cnt == W_MAX) frame_bad <= 1'b1;
      else pix_cnt <= pix_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt <= '0;
    else if (vs_rise) to_cnt <= '0;
    else if (state != NOSIG && to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= NOSIG;
      frame_start   <= 1'b0;
      locked        <= 1'b0;
      mode_o        <= '0;
      active_width  <= '0;
      active_height <= '0;
      match_cnt     <= '0;
      ref_w         <= '0;
      ref_h         <= '0;
      last_bad      <= 1'b0;
      lock_lost     <= 1'b0;
    end else begin
      frame_start <= vs_rise;
      if (vs_rise && state != NOSIG) begin
        match_cnt <= match_next;
        last_bad  <= ~good;
        if (good && !same) begin
          ref_w <= w_eval;
          ref_h <= h_eval;
        end
      end
      case (state)
        NOSIG: begin
          if (vs_rise) begin
            state     <= MEASURE;
            match_cnt <= '0;
          end
        end
        MEASURE: begin
          if (vs_rise) begin
            if (match_next == MATCH_LOCK) begin
              state         <= LOCKED;
              locked        <= 1'b1;
              active_width  <= w_eval;
              active_height <= h_eval;
              mode_o        <= mode_sync;
            end
          end else if (timeout) begin
            state <= NOSIG;
          end
        end
        LOCKED: begin
          if (vs_rise) begin
            if (good && same) begin
              mode_o <= mode_sync;
            end else begin
              state     <= MEASURE;
              locked    <= 1'b0;
              mode_o    <= '0;
              lock_lost <= 1'b1;
            end
          end else if (timeout) begin
            state     <= NOSIG;
            locked    <= 1'b0;
            mode_o    <= '0;
            lock_lost <= 1'b1;
          end
        end
        default: begin
          state  <= NOSIG;
          locked <= 1'b0;
          mode_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed bench for video_mode_ctrl: lock, mode switching, bad line, timeout,
// boundary collisions and asynchronous reset, with hand-computed expectations.
module tb_video_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        de = 1'b0;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic [1:0]  mode_sw = 2'd0;
  logic [1:0]  mode_o;
  logic        frame_start;
  logic        locked;
  logic [11:0] active_width;
  logic [11:0] active_height;
  logic [3:0]  status;

  int errors = 0;
  int checks = 0;
  int fs_count = 0;

  video_mode_ctrl #(
    .WIDTH_BITS(12), .HEIGHT_BITS(12), .LOCK_FRAMES(2), .FRAME_TIMEOUT(1000)
  ) dut (
    .clk(clk), .rst(rst), .de(de), .hs(hs), .vs(vs), .mode_sw(mode_sw),
    .mode_o(mode_o), .frame_start(frame_start), .locked(locked),
    .active_width(active_width), .active_height(active_height), .status(status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_start) fs_count++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    tick();
    tick();
  endtask

  // 3 + h*(w+4) + 3 cycles; line bad_idx is bad_w pixels wide instead of w
  task automatic lines(input int w, input int h, input int bad_idx, input int bad_w);
    vs = 1'b0;
    repeat (3) tick();
    for (int l = 0; l < h; l++) begin
      de = 1'b1;
      repeat ((l == bad_idx) ? bad_w : w) tick();
      de = 1'b0;
      repeat (4) tick();
    end
    repeat (3) tick();
  endtask

  // last DE fall and VS rise are sampled on the same edge
  task automatic frame_collide(input int w, input int h);
    vs = 1'b0;
    repeat (3) tick();
    for (int l = 0; l < h; l++) begin
      de = 1'b1;
      repeat (w) tick();
      de = 1'b0;
      if (l == h - 1) vs = 1'b1;
      else repeat (4) tick();
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_locked", locked, 0);
    chk("rst_mode", mode_o, 0);
    chk("rst_status", status, 0);
    chk("rst_fs", frame_start, 0);
    rst = 1'b1;
    tick();

    vs_pulse();
    chk("f0_status", status, 4'b0001);
    lines(16, 8, -1, 0);
    vs_pulse();
    chk("f1_status", status, 4'b0001);
    chk("f1_locked", locked, 0);
    lines(16, 8, -1, 0);
    vs = 1'b1;
    tick();
    chk("f2_locked_early", locked, 0);
    tick();
    chk("f2_locked", locked, 1);
    chk("f2_width", active_width, 16);
    chk("f2_height", active_height, 8);
    chk("f2_status", status, 4'b0010);
    chk("f2_mode", mode_o, 0);
    tick();
    chk("fs_one_cycle", frame_start, 0);
    chk("fs_count", fs_count, 3);

    mode_sw = 2'b10;
    lines(16, 8, -1, 0);
    chk("mode_mid_frame", mode_o, 0);
    vs = 1'b1;
    tick();
    chk("mode_early", mode_o, 0);
    tick();
    chk("mode_applied", mode_o, 2'b10);

    lines(16, 8, 3, 15);
    vs_pulse();
    chk("bad_locked", locked, 0);
    chk("bad_mode", mode_o, 0);
    chk("bad_status", status, 4'b1101);
    lines(16, 8, -1, 0);
    vs_pulse();
    chk("relock1_locked", locked, 0);
    chk("relock1_status", status, 4'b1001);
    lines(16, 8, -1, 0);
    vs_pulse();
    chk("relock2_locked", locked, 1);
    chk("relock2_status", status, 4'b1010);
    chk("relock2_mode", mode_o, 2'b10);

    vs = 1'b0;
    repeat (999) tick();
    chk("to_999_status", status, 4'b1010);
    tick();
    chk("to_1000_status", status, 4'b1000);
    chk("to_locked", locked, 0);
    chk("to_mode", mode_o, 0);

    vs_pulse();
    chk("resync_status", status, 4'b1001);
    lines(16, 8, -1, 0);
    vs_pulse();
    frame_collide(16, 8);
    tick();
    tick();
    chk("coll_locked", locked, 1);
    chk("coll_height", active_height, 8);
    chk("coll_width", active_width, 16);

    lines(16, 8, -1, 0);
    repeat (832) tick();
    vs = 1'b1;
    tick();
    tick();
    chk("to_coll_status", status, 4'b1010);
    chk("to_coll_fs", frame_start, 1);
    vs = 1'b0;
    repeat (5) tick();
    chk("to_coll_after", locked, 1);

    de = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_mode", mode_o, 0);
    chk("arst_width", active_width, 0);
    chk("arst_height", active_height, 0);
    chk("arst_status", status, 0);
    de = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_status", status, 0);
    chk("post_rst_mode", mode_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
